axa_error_monitor: RTL

AXA_ERROR_MONITOR -- requirements
Module: axa_error_monitor

---
 rtl/axa_pkg.sv | 18 +
 rtl/axa_ed_calc.sv | 19 +
 rtl/axa_error_monitor.sv | 107 ++++++++++
 3 files changed

// File: rtl/axa_pkg.sv
// axa_pkg: shared state encoding and width helpers for the approximate-adder error monitor
package axa_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic int cw_of(input int samples);
        return $clog2(samples) + 1;
    endfunction

    function automatic int aw_of(input int width, input int samples);
        return width + 1 + $clog2(samples);
    endfunction

    function automatic int sw_of(input int width, input int samples);
        return 2 * (width + 1) + $clog2(samples);
    endfunction

endpackage

// File: rtl/axa_ed_calc.sv
// axa_ed_calc: exact sum of the operands and its absolute distance from the approximate result
module axa_ed_calc #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH:0]   approx_sum,
    output logic [WIDTH:0]   ed
);

    logic [WIDTH:0] exact;

    // carry-out kept as MSB so exact and approx_sum compare at equal width
    always_comb begin
        exact = {1'b0, op_a} + {1'b0, op_b};
        ed    = (exact >= approx_sum) ? exact - approx_sum : approx_sum - exact;
    end

endmodule

// File: rtl/axa_error_monitor.sv
// axa_error_monitor: windowed error statistics for an approximate adder (AXA_ERRMON_SQERR_EN adds squared-error sum)
module axa_error_monitor
    import axa_pkg::*;
#(
    parameter  int WIDTH   = 16,
    parameter  int SAMPLES = 1024,
    localparam int CW      = cw_of(SAMPLES),
    localparam int AW      = aw_of(WIDTH, SAMPLES),
    localparam int SW      = sw_of(WIDTH, SAMPLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH:0]   approx_sum,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    sample_count,
    output logic [CW-1:0]    err_count,
    output logic [AW-1:0]    ed_sum,
    output logic [WIDTH:0]   ed_max,
    output logic [SW-1:0]    sq_sum
);

    localparam logic [CW-1:0] LAST = CW'(SAMPLES - 1);

    state_t         state, state_nx;
    logic           accept, clear, last_accept, drain_cnt, s1_valid;
    logic [WIDTH:0] ed_w, s1_ed;

    assign in_ready    = (state == RUN);
    assign busy        = (state == RUN);
    assign done        = (state == DONE);
    assign accept      = in_valid & in_ready;
    assign clear       = start & ((state == IDLE) | (state == DONE));
    assign last_accept = accept & (sample_count == LAST);

    axa_ed_calc #(.WIDTH(WIDTH)) u_ed_calc (
        .op_a       (op_a),
        .op_b       (op_b),
        .approx_sum (approx_sum),
        .ed         (ed_w)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state: start only honoured from IDLE/DONE, drain covers the two pipeline stages
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  state_nx = start       ? RUN   : IDLE;
            RUN:   state_nx = last_accept ? DRAIN : RUN;
            DRAIN: state_nx = drain_cnt   ? DONE  : DRAIN;
            DONE:  state_nx = start       ? RUN   : DONE;
        endcase
    end

    // ED register, drain timer and accumulators
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_ed        <= '0;
            drain_cnt    <= 1'b0;
            sample_count <= '0;
            err_count    <= '0;
            ed_sum       <= '0;
            ed_max       <= '0;
        end else begin
            s1_valid  <= accept;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            if (accept) s1_ed <= ed_w;
            if (clear) begin
                s1_valid     <= 1'b0;
                sample_count <= '0;
                err_count    <= '0;
                ed_sum       <= '0;
                ed_max       <= '0;
            end else begin
                if (accept) sample_count <= sample_count + CW'(1);
                if (s1_valid) begin
                    err_count <= err_count + CW'(s1_ed != '0);
                    ed_sum    <= ed_sum + AW'(s1_ed);
                    ed_max    <= (s1_ed > ed_max) ? s1_ed : ed_max;
                end
            end
        end
    end

`ifdef AXA_ERRMON_SQERR_EN
    // squared-error accumulator, same timing as the other stage-2 statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           sq_sum <= '0;
        else if (clear)    sq_sum <= '0;
        else if (s1_valid) sq_sum <= sq_sum + SW'(s1_ed) * SW'(s1_ed);
    end
`else
    assign sq_sum = '0;
`endif

endmodule
